// File: rtl/seg_pkg.sv
// Shared constants and hex decode for the 7-segment display blocks.
// Segment codes are active-low for a common-anode display.
package seg_pkg;

  localparam int CLK_INNER_DEFAULT = 27_000_000;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Bit 7 (dp) is always high, so the decimal point stays dark.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
    logic [7:0] code;
    case (hex)
      4'h0:    code = 8'hC0;
      4'h1:    code = 8'hF9;
      4'h2:    code = 8'hA4;
      4'h3:    code = 8'hB0;
      4'h4:    code = 8'h99;
      4'h5:    code = 8'h92;
      4'h6:    code = 8'h82;
      4'h7:    code = 8'hF8;
      4'h8:    code = 8'h80;
      4'h9:    code = 8'h90;
      4'hA:    code = 8'h88;
      4'hB:    code = 8'h83;
      4'hC:    code = 8'hC6;
      4'hD:    code = 8'hA1;
      4'hE:    code = 8'h86;
      default: code = 8'h8E;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-to-segment decoder, shared with the static display designs.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg_n
);

  assign seg_n = hex_to_seg(hex);

endmodule

// File: rtl/seg_scroll_mux.sv
// Multiplexed common-anode display driver showing a scrolling window of a
// 16-nibble message; offset and message are captured only at frame start.
module seg_scroll_mux
  import seg_pkg::*;
#(
  parameter int CLK_INNER    = CLK_INNER_DEFAULT,
  parameter int REFRESH_HZ   = 250,
  parameter int DIGITS       = 4,
  parameter int BLANK_CYCLES = 270
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [3:0]        shift,
  input  logic [63:0]       msg,
  output logic [7:0]        seg_n,
  output logic [DIGITS-1:0] dig_n
);

  localparam int P  = CLK_INNER / (REFRESH_HZ * DIGITS);
  localparam int CW = (P > 2) ? $clog2(P) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (P < 2) begin : g_chk_p
    $error("seg_scroll_mux: slot length P must be at least 2");
  end
  if (BLANK_CYCLES >= P) begin : g_chk_blank
    $error("seg_scroll_mux: BLANK_CYCLES must be smaller than P");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_chk_digits
    $error("seg_scroll_mux: DIGITS must be in 1..8");
  end

  logic [CW-1:0]     cnt, cnt_nx;
  logic [DW-1:0]     d, d_nx;
  logic [3:0]        shift_q, shift_nx;
  logic [63:0]       msg_q, msg_nx;
  logic [3:0]        idx;
  logic [3:0]        nib;
  logic [7:0]        seg_dec;
  logic              blank_nx;
  logic [DIGITS-1:0] dig_sel;

  always_comb begin
    cnt_nx   = cnt + CW'(1);
    d_nx     = d;
    shift_nx = shift_q;
    msg_nx   = msg_q;
    if (cnt == CW'(P - 1)) begin
      cnt_nx = '0;
      if (d == DW'(DIGITS - 1)) begin
        d_nx     = '0;
        shift_nx = shift;
        msg_nx   = msg;
      end else begin
        d_nx = d + DW'(1);
      end
    end
  end

  // Outputs are decoded from next-state values so the registered pins line
  // up with the counter value of the same cycle.
  assign idx      = shift_nx + 4'(d_nx);
  assign nib      = msg_nx[{idx, 2'b00} +: 4];
  assign blank_nx = (cnt_nx < CW'(BLANK_CYCLES));
  assign dig_sel  = ~(DIGITS'(1) << d_nx);

  hex_to_seg7 u_dec (
    .hex   (nib),
    .seg_n (seg_dec)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt     <= '0;
      d       <= '0;
      shift_q <= '0;
      msg_q   <= '0;
      seg_n   <= SEG_BLANK;
      dig_n   <= '1;
    end else begin
      cnt     <= cnt_nx;
      d       <= d_nx;
      shift_q <= shift_nx;
      msg_q   <= msg_nx;
      if (blank_nx) begin
        seg_n <= SEG_BLANK;
        dig_n <= '1;
      end else begin
        seg_n <= seg_dec;
        dig_n <= dig_sel;
      end
    end
  end

endmodule

// File: tb/tb_seg_scroll_mux.sv
// Bench for seg_scroll_mux at P=4, four digits, one blank cycle per slot.
module tb_seg_scroll_mux;

  localparam int DIGITS = 4;
  localparam int P      = 4;
  localparam int FRAME  = DIGITS * P;
  localparam int BLANK  = 1;

  logic        clk;
  logic        nrst;
  logic [3:0]  shift;
  logic [63:0] msg;
  logic [7:0]  seg_n;
  logic [3:0]  dig_n;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: cycles since reset release, and the values latched at frame start
  int          edges;
  logic [3:0]  m_shift;
  logic [63:0] m_msg;
  logic [7:0]  seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scroll_mux #(
    .CLK_INNER    (80),
    .REFRESH_HZ   (5),
    .DIGITS       (DIGITS),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk   (clk),
    .nrst  (nrst),
    .shift (shift),
    .msg   (msg),
    .seg_n (seg_n),
    .dig_n (dig_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      edges   = 0;
      m_shift = 4'd0;
      m_msg   = 64'd0;
    end else begin
      if (edges % FRAME == FRAME - 1) begin
        m_shift = shift;
        m_msg   = msg;
      end
      edges = edges + 1;
    end
  end

  always @(negedge clk) begin
    int p, c, dd, ch;
    logic [7:0] exp_seg;
    logic [3:0] exp_dig;
    if (!nrst) begin
      chk("reset_seg", seg_n, 8'hFF);
      chk("reset_dig", {4'h0, dig_n}, 8'h0F);
    end else begin
      p  = edges % FRAME;
      c  = p % P;
      dd = p / P;
      if (c < BLANK) begin
        exp_seg = 8'hFF;
        exp_dig = 4'hF;
      end else begin
        ch      = (int'(m_shift) + dd) % 16;
        exp_seg = seg_tbl[(m_msg >> (4 * ch)) & 64'hF];
        exp_dig = ~(4'b0001 << dd);
      end
      chk("model_seg", seg_n, exp_seg);
      chk("model_dig", {4'h0, dig_n}, {4'h0, exp_dig});
      chk("one_hot", 8'($countones(~dig_n) <= 1), 8'd1);
      if (c == 0) chk("cnt0_blank", {4'h0, dig_n}, 8'h0F);
      if (dig_n == 4'hF) chk("off_seg_blank", seg_n, 8'hFF);
    end
  end

  task automatic wait_edge(input int n);
    int guard = 0;
    while (edges < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (edges != n) begin
      n_fail++;
      $display("FAIL wait_edge: reached %0d, wanted %0d", edges, n);
    end
  endtask

  task automatic lit(input string name, input int e, input logic [7:0] s, input logic [3:0] dg);
    wait_edge(e);
    chk({name, "_seg"}, seg_n, s);
    chk({name, "_dig"}, {4'h0, dig_n}, {4'h0, dg});
  endtask

  initial begin
    int cnt_lit;
    nrst  = 1'b1;
    shift = 4'd0;
    msg   = 64'hFEDCBA9876543210;
    #1 nrst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg_lit", seg_n, 8'hFF);
    nrst = 1'b1;

    // frame 0 still shows the reset-latched message
    lit("f0_d0", 1, 8'hC0, 4'b1110);
    lit("f0_d2", 9, 8'hC0, 4'b1011);
    // frame 1: window at offset 0
    lit("win_d0", 17, 8'hC0, 4'b1110);
    lit("win_d1", 21, 8'hF9, 4'b1101);
    lit("win_d2", 25, 8'hA4, 4'b1011);
    lit("win_d3", 29, 8'hB0, 4'b0111);
    shift = 4'd13;
    lit("wrap_d0", 33, 8'hA1, 4'b1110);
    lit("wrap_d1", 37, 8'h86, 4'b1101);
    lit("wrap_d2", 41, 8'h8E, 4'b1011);
    lit("wrap_d3", 45, 8'hC0, 4'b0111);
    shift = 4'd0;
    lit("tear_d0", 49, 8'hC0, 4'b1110);
    lit("tear_d1", 53, 8'hF9, 4'b1101);
    shift = 4'd1;
    lit("tear_d2", 57, 8'hA4, 4'b1011);
    lit("tear_d3", 61, 8'hB0, 4'b0111);
    lit("next_d0", 65, 8'hF9, 4'b1110);
    lit("next_d1", 69, 8'hA4, 4'b1101);
    lit("next_d2", 73, 8'hB0, 4'b1011);
    lit("next_d3", 77, 8'h99, 4'b0111);

    cnt_lit = 0;
    for (int e = 80; e < 84; e++) begin
      wait_edge(e);
      if (dig_n == 4'b1110) cnt_lit++;
    end
    chk("lit_cycles", 8'(cnt_lit), 8'd3);

    // reset in the middle of a lit slot blanks immediately
    wait_edge(86);
    #2 nrst = 1'b0;
    #1;
    chk("midrst_seg", seg_n, 8'hFF);
    chk("midrst_dig", {4'h0, dig_n}, 8'h0F);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    lit("rel_cnt0", 0, 8'hFF, 4'b1111);
    lit("rel_first", 1, 8'hC0, 4'b1110);

    for (int i = 0; i < 100 * FRAME; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) shift = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) msg = {$urandom, $urandom};
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
